// File: rtl/mvb_frame_decoder.sv
// MVB Manchester frame decoder: checks the start delimiter after a frame_start pulse,
// then decodes half-bit pairs into data bits until a non-data symbol or overflow.
module mvb_frame_decoder #(
    parameter int                      CLK_PER_HALF = 8,
    parameter int                      SAMPLE_PT    = 3,
    parameter int                      DELIM_HALVES = 16,
    parameter logic [DELIM_HALVES-1:0] MASTER_DELIM = 16'hC3A5,
    parameter logic [DELIM_HALVES-1:0] SLAVE_DELIM  = 16'h3CA5,
    parameter int                      MAX_BITS     = 256
) (
    input  logic       clk_24M,
    input  logic       rst,
    input  logic       data_in,
    input  logic       frame_start,
    output logic       frame_type,
    output logic       delim_ok,
    output logic       delim_err,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       frame_end,
    output logic       code_err,
    output logic [8:0] bit_count
);

    localparam int CW = $clog2(CLK_PER_HALF);
    localparam int DW = $clog2(DELIM_HALVES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELIM = 2'd1,
        DATA  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [CW-1:0]           cnt_r, cnt_s;
    logic [DELIM_HALVES-1:0] shift_r, shift_s;
    logic [DW-1:0]           halves_r, halves_s;
    logic                    first_r, first_s;
    logic                    phase_r, phase_s;
    logic                    frame_type_r, frame_type_s;
    logic                    bit_out_r, bit_out_s;
    logic [8:0]              bit_count_r, bit_count_s;
    logic                    delim_ok_s, delim_err_s, bit_valid_s, frame_end_s, code_err_s;
    logic                    delim_ok_r, delim_err_r, bit_valid_r, frame_end_r, code_err_r;
    logic                    sample_s;
    logic [DELIM_HALVES-1:0] delim_word_s;

    assign sample_s     = (state_r != IDLE) && (cnt_r == CW'(SAMPLE_PT));
    assign delim_word_s = {shift_r[DELIM_HALVES-2:0], data_in};

    // Next-state and next-output logic; results are registered so every output is a flop.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shift_s      = shift_r;
        halves_s     = halves_r;
        first_s      = first_r;
        phase_s      = phase_r;
        frame_type_s = frame_type_r;
        bit_out_s    = bit_out_r;
        bit_count_s  = bit_count_r;
        delim_ok_s   = 1'b0;
        delim_err_s  = 1'b0;
        bit_valid_s  = 1'b0;
        frame_end_s  = 1'b0;
        code_err_s   = 1'b0;

        // IDLE keeps cnt at 0, so the frame_start cycle counts as half-bit cycle 0.
        if (state_r == IDLE) begin
            cnt_s = '0;
        end else if (cnt_r == CW'(CLK_PER_HALF - 1)) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + CW'(1);
        end

        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_s     = DELIM;
                    cnt_s       = CW'(1);
                    bit_count_s = 9'd0;
                    shift_s     = '0;
                    halves_s    = '0;
                    phase_s     = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            DELIM: begin
                if (sample_s) begin
                    shift_s  = delim_word_s;
                    halves_s = halves_r + DW'(1);
                    if (halves_r == DW'(DELIM_HALVES - 1)) begin
                        if (delim_word_s == MASTER_DELIM) begin
                            frame_type_s = 1'b0;
                            delim_ok_s   = 1'b1;
                            state_s      = DATA;
                        end else if (delim_word_s == SLAVE_DELIM) begin
                            frame_type_s = 1'b1;
                            delim_ok_s   = 1'b1;
                            state_s      = DATA;
                        end else begin
                            delim_err_s = 1'b1;
                            state_s     = IDLE;
                            cnt_s       = '0;
                        end
                    end else begin
                        state_s = DELIM;
                    end
                end else begin
                    state_s = DELIM;
                end
            end
            DATA: begin
                if (sample_s) begin
                    if (!phase_r) begin
                        first_s = data_in;
                        phase_s = 1'b1;
                    end else begin
                        phase_s = 1'b0;
                        if (first_r != data_in) begin
                            bit_out_s   = first_r;
                            bit_valid_s = 1'b1;
                            bit_count_s = bit_count_r + 9'd1;
                            if (bit_count_r == 9'(MAX_BITS - 1)) begin
                                code_err_s = 1'b1;
                                state_s    = FLUSH;
                            end else begin
                                state_s = DATA;
                            end
                        end else begin
                            // Non-data symbol: a frame with no bits counts as an abort.
                            if (bit_count_r != 9'd0) begin
                                frame_end_s = 1'b1;
                            end else begin
                                code_err_s = 1'b1;
                            end
                            state_s = FLUSH;
                        end
                    end
                end else begin
                    state_s = DATA;
                end
            end
            FLUSH: begin
                // Evaluation cycle: a coincident frame_start is deliberately dropped here.
                state_s = IDLE;
                cnt_s   = '0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            shift_r      <= '0;
            halves_r     <= '0;
            first_r      <= 1'b0;
            phase_r      <= 1'b0;
            frame_type_r <= 1'b0;
            bit_out_r    <= 1'b0;
            bit_count_r  <= 9'd0;
            delim_ok_r   <= 1'b0;
            delim_err_r  <= 1'b0;
            bit_valid_r  <= 1'b0;
            frame_end_r  <= 1'b0;
            code_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            shift_r      <= shift_s;
            halves_r     <= halves_s;
            first_r      <= first_s;
            phase_r      <= phase_s;
            frame_type_r <= frame_type_s;
            bit_out_r    <= bit_out_s;
            bit_count_r  <= bit_count_s;
            delim_ok_r   <= delim_ok_s;
            delim_err_r  <= delim_err_s;
            bit_valid_r  <= bit_valid_s;
            frame_end_r  <= frame_end_s;
            code_err_r   <= code_err_s;
        end
    end

    assign frame_type = frame_type_r;
    assign delim_ok   = delim_ok_r;
    assign delim_err  = delim_err_r;
    assign bit_out    = bit_out_r;
    assign bit_valid  = bit_valid_r;
    assign frame_end  = frame_end_r;
    assign code_err   = code_err_r;
    assign bit_count  = bit_count_r;

endmodule

// File: tb/tb_mvb_frame_decoder.sv
// Directed bench for mvb_frame_decoder: builds half-bit streams, records output pulses
// with their cycle numbers and compares them with hand-derived timing and data.
module tb_mvb_frame_decoder;

    logic       clk_24M = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_type, delim_ok, delim_err, bit_out, bit_valid, frame_end, code_err;
    logic [8:0] bit_count;

    mvb_frame_decoder dut (
        .clk_24M    (clk_24M),
        .rst        (rst),
        .data_in    (data_in),
        .frame_start(frame_start),
        .frame_type (frame_type),
        .delim_ok   (delim_ok),
        .delim_err  (delim_err),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .frame_end  (frame_end),
        .code_err   (code_err),
        .bit_count  (bit_count)
    );

    always #20 clk_24M = ~clk_24M;

    int cyc = 0;
    always @(posedge clk_24M) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic halves[$];
    logic bits[$];
    int   vcyc[$];
    int   fs_cyc, n_ok, n_err, n_end, n_cerr, ok_cyc, err_cyc, end_cyc, cerr_cyc;
    int   ft_at_ok, end_count, cerr_count;
    logic exp_ovf[256];

    task automatic check(input string tag, input int got, input int exp);
        checks += 1;
        if (got !== exp) begin
            failures += 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({frame_type, delim_ok, delim_err, bit_out, bit_valid, frame_end, code_err, bit_count});
    endfunction

    // Event recorder: captures every pulse once per cycle, away from the active edge.
    initial forever begin
        @(negedge clk_24M);
        if (rst === 1'b1) begin
            if (bit_valid) begin bits.push_back(bit_out); vcyc.push_back(cyc); end
            if (delim_ok)  begin n_ok += 1; ok_cyc = cyc; ft_at_ok = int'(frame_type); end
            if (delim_err) begin n_err += 1; err_cyc = cyc; end
            if (frame_end) begin n_end += 1; end_cyc = cyc; end_count = int'(bit_count); end
            if (code_err)  begin n_cerr += 1; cerr_cyc = cyc; cerr_count = int'(bit_count); end
        end
    end

    task automatic add_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) halves.push_back(w[i]);
    endtask

    task automatic add_bit(input logic b);
        halves.push_back(b);
        halves.push_back(~b);
    endtask

    task automatic add_sym(input logic a, input logic b);
        halves.push_back(a);
        halves.push_back(b);
    endtask

    // Drives n cycles: frame_start in cycle 0 (and at extra_fs if >= 0), half k over cycles 8k..8k+7.
    task automatic drive_frame(input int n, input int extra_fs);
        bits.delete();
        vcyc.delete();
        n_ok = 0; n_err = 0; n_end = 0; n_cerr = 0;
        ok_cyc = -1; err_cyc = -1; end_cyc = -1; cerr_cyc = -1;
        end_count = -1; cerr_count = -1; ft_at_ok = -1;
        @(posedge clk_24M); #1;
        fs_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin @(posedge clk_24M); #1; end
            frame_start = (i == 0) || (i == extra_fs);
            data_in = (i / 8 < halves.size()) ? halves[i / 8] : 1'b1;
        end
        @(posedge clk_24M); #1;
        frame_start = 1'b0;
        data_in = 1'b1;
        halves.delete();
    endtask

    task automatic master_1011(input string pfx);
        int w;
        add_word(16'hC3A5);
        add_bit(1'b1); add_bit(1'b0); add_bit(1'b1); add_bit(1'b1);
        add_sym(1'b1, 1'b1);
        drive_frame(26 * 8 + 200, 26 * 8 - 4);
        w = 0;
        foreach (bits[i]) w = (w << 1) | int'(bits[i]);
        check({pfx, "_ok_cnt"}, n_ok, 1);
        check({pfx, "_ok_cyc"}, ok_cyc, fs_cyc + 124);
        check({pfx, "_ftype"}, ft_at_ok, 0);
        check({pfx, "_nbits"}, bits.size(), 4);
        check({pfx, "_bits"}, w, 'b1011);
        check({pfx, "_v0_cyc"}, (vcyc.size() > 0) ? vcyc[0] : -1, fs_cyc + 140);
        check({pfx, "_v_span"}, (vcyc.size() == 4) ? vcyc[3] - vcyc[0] : -1, 48);
        check({pfx, "_end_cnt"}, n_end, 1);
        check({pfx, "_end_cyc"}, end_cyc, fs_cyc + 204);
        check({pfx, "_end_count"}, end_count, 4);
        check({pfx, "_no_cerr"}, n_cerr, 0);
        check({pfx, "_drop_fs"}, n_ok + n_err, 1);
    endtask

    initial begin
        int w;
        int mism;

        // Reset held while inputs toggle.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_24M); #1;
            data_in = ~data_in;
            frame_start = (i % 2 == 0);
            if (i % 5 == 4) check("rst_hold", out_vec(), 0);
        end
        @(posedge clk_24M); #1;
        frame_start = 1'b0;
        data_in = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_24M); #1;
            if (i % 10 == 9) check("rst_idle", out_vec(), 0);
        end

        // Master frame; a frame_start in the terminating evaluation cycle must be dropped.
        master_1011("mst");

        // Slave frame with 16 data bits.
        add_word(16'h3CA5);
        for (int i = 15; i >= 0; i--) add_bit(((16'hA5C3 >> i) & 1) != 0);
        add_sym(1'b0, 1'b0);
        drive_frame(50 * 8 + 20, -1);
        w = 0;
        foreach (bits[i]) w = (w << 1) | int'(bits[i]);
        check("slv_ftype", ft_at_ok, 1);
        check("slv_ftype_hold", int'(frame_type), 1);
        check("slv_bits", w, 'hA5C3);
        check("slv_nbits", bits.size(), 16);
        check("slv_end_cnt", n_end, 1);
        check("slv_end_count", end_count, 16);
        check("slv_count_hold", int'(bit_count), 16);

        // Bad delimiter with a second frame_start inside DELIM.
        add_word(16'hFFFF);
        drive_frame(16 * 8 + 200, 40);
        check("bad_err_cnt", n_err, 1);
        check("bad_err_cyc", err_cyc, fs_cyc + 124);
        check("bad_no_ok", n_ok, 0);
        check("bad_no_bits", bits.size(), 0);

        // Empty frame.
        add_word(16'hC3A5);
        add_sym(1'b1, 1'b1);
        drive_frame(18 * 8 + 20, -1);
        check("empty_cerr_cnt", n_cerr, 1);
        check("empty_cerr_cyc", cerr_cyc, fs_cyc + 140);
        check("empty_count", cerr_count, 0);
        check("empty_no_end", n_end, 0);

        // Overflow: 256 valid bits.
        add_word(16'hC3A5);
        for (int j = 0; j < 256; j++) begin
            exp_ovf[j] = (((j * 7) >> 2) & 1) != 0;
            add_bit(exp_ovf[j]);
        end
        add_sym(1'b1, 1'b1);
        drive_frame((16 + 514) * 8 + 20, -1);
        mism = 0;
        for (int j = 0; j < 256; j++) if (j >= bits.size() || bits[j] !== exp_ovf[j]) mism += 1;
        check("ovf_nbits", bits.size(), 256);
        check("ovf_bits_mism", mism, 0);
        check("ovf_cerr_cnt", n_cerr, 1);
        check("ovf_cerr_cyc", cerr_cyc, fs_cyc + 140 + 16 * 255);
        check("ovf_last_v_cyc", (vcyc.size() == 256) ? vcyc[255] : -1, cerr_cyc);
        check("ovf_count", cerr_count, 256);
        check("ovf_no_end", n_end, 0);

        // Mid-frame reset after three decoded bits.
        add_word(16'hC3A5);
        add_bit(1'b1); add_bit(1'b0); add_bit(1'b1); add_bit(1'b1); add_bit(1'b0);
        drive_frame(180, -1);
        check("mid_bits_before", bits.size(), 3);
        #5;
        rst = 1'b0;
        #1;
        check("mid_rst_async", out_vec(), 0);
        repeat (5) @(posedge clk_24M);
        #1;
        rst = 1'b1;
        n_end = 0;
        n_cerr = 0;
        repeat (30) @(posedge clk_24M);
        #1;
        check("mid_no_end", n_end, 0);
        check("mid_no_cerr", n_cerr, 0);
        check("mid_idle_out", out_vec(), 0);
        master_1011("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mvb_frame_decoder.md
Name: mvb_frame_decoder

Overview:
- Manchester decoder for the MVB receive path at 24 MHz: 16 clocks per bit, 8 clocks per half-bit.
- Sits directly downstream of the start-edge detector. It consumes that block's one-cycle frame_start pulse and the same raw serial line.
- Checks the start delimiter against master and slave patterns, then emits decoded data bits one at a time.
- Terminates the frame on a non-data symbol or on overflow.

Parameters:
- CLK_PER_HALF, 8, clocks per Manchester half-bit.
- SAMPLE_PT, 3, counter value at which data_in is sampled within each half-bit.
- DELIM_HALVES, 16, number of half-bit samples in the start delimiter.
- MASTER_DELIM, 16'hC3A5, expected delimiter half-bit pattern for a master frame. MSB is the first sample.
- SLAVE_DELIM, 16'h3CA5, expected delimiter half-bit pattern for a slave frame.
- MAX_BITS, 256, maximum number of data bits per frame.

Ports:
- clk_24M  input  1  24 MHz system clock
- rst  input  1  asynchronous reset, active low
- data_in  input  1  raw serial line, same signal that drives the start detector
- frame_start  input  1  one-cycle pulse from the start detector; marks the first delimiter half-bit
- frame_type  output  1  0 = master, 1 = slave; valid from the delim_ok pulse until the next frame
- delim_ok  output  1  one-cycle pulse: delimiter matched
- delim_err  output  1  one-cycle pulse: delimiter matched neither pattern
- bit_out  output  1  decoded data bit
- bit_valid  output  1  one-cycle strobe qualifying bit_out
- frame_end  output  1  one-cycle pulse: frame terminated normally
- code_err  output  1  one-cycle pulse: frame aborted (overflow or empty frame)
- bit_count  output  9  data bits decoded in the current or last frame

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE;
  - all pulse outputs 0;
  - bit_out, frame_type and bit_count 0;
  - half-bit counter and shift register 0.
- Half-bit counter cnt (0..CLK_PER_HALF-1):
  - cleared to 0 in the cycle frame_start is seen in IDLE;
  - increments every cycle outside IDLE and wraps from CLK_PER_HALF-1 to 0.
  - data_in is sampled when cnt==SAMPLE_PT.
  - There is no edge resynchronisation; sampling is free-running from frame_start.
- frame_start is ignored in every state except IDLE.
- IDLE:
  - on frame_start go to DELIM;
  - clear the half-bit counter, bit_count and the delimiter shift register.
- DELIM:
  - shift each sample into a 16-bit register, MSB first.
  - After the DELIM_HALVES-th sample, evaluate in the next cycle:
    - match MASTER_DELIM: frame_type<=0, pulse delim_ok, go to DATA;
    - match SLAVE_DELIM: frame_type<=1, pulse delim_ok, go to DATA;
    - no match: pulse delim_err, go to IDLE.
- DATA: samples are paired as first half, second half. Evaluate each pair the cycle after its second sample.
  - 1,0: bit_out<=1, bit_valid pulse, bit_count+1.
  - 0,1: bit_out<=0, bit_valid pulse, bit_count+1.
  - 0,0 or 1,1 (non-data symbol):
    - if bit_count>0: pulse frame_end;
    - else: pulse code_err;
    - go to IDLE in both cases.
  - After a valid bit that brings bit_count to MAX_BITS: pulse code_err and go to IDLE. The bit_valid for that bit is still issued in the same cycle.
- bit_count holds its value in IDLE until the next frame_start.
- The first data half-bit sample occurs (DELIM_HALVES*CLK_PER_HALF + SAMPLE_PT) cycles after frame_start.
- Bit latency: bit_valid asserts 1 cycle after the second half-bit sample, i.e. CLK_PER_HALF+1 cycles after the first.
- Reset mid-frame aborts immediately with no frame_end or code_err pulse.
- A frame_start that coincides with the evaluation cycle in DATA is dropped. The decoder returns to IDLE and waits for the next pulse.

Test Plan:
- Reset: hold rst=0 while toggling data_in and frame_start -> all outputs 0. After release with the line idle high, outputs stay 0.
- Master frame: frame_start, MASTER_DELIM halves, bits 1,0,1,1, then a 1,1 symbol.
  - delim_ok=1 with frame_type=0;
  - four bit_valid strobes with bit_out 1,0,1,1, spaced 16 clocks apart;
  - frame_end=1 and bit_count=4.
- Slave frame: SLAVE_DELIM, 16 bits 0xA5C3, then a 0,0 symbol -> frame_type=1, bits match MSB first, frame_end with bit_count=16.
- Bad delimiter: pattern 16'hFFFF -> delim_err pulse exactly 1 cycle after the 16th sample, with no bit_valid. A second frame_start during DELIM is ignored.
- Empty frame / overflow:
  - valid delimiter then immediately 1,1 -> code_err=1 and bit_count=0;
  - valid delimiter then 256 valid bits -> 256 strobes, code_err on the 256th, no frame_end.
- Mid-frame reset: assert rst after 3 decoded bits -> outputs 0 asynchronously. A new master frame afterwards decodes correctly.
